// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM states, Rcon table and S-box.
// The S-box is computed as GF(2^8) inverse plus affine map, so there is no 256-entry constant to mistype.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_t;

  // Indexed directly by the 4-bit round counter; entries 11..15 are never used.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/key_expand_round.sv
// One AES-128 key-expansion step, purely combinational (zero latency).
// No flow control: output follows the inputs in the same cycle.
module key_expand_round
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [3:0]       round,
  output logic [KEY_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] tw;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;

  assign tw = sub_word({w3[23:0], w3[31:24]}) ^ {RCON[round], 24'h000000};

  assign n0 = w0 ^ tw;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule.sv
// AES-128 round-key generator: one round key per cycle, keys_valid 10 edges after accept.
// key_ready drops during expansion; keys offered then are dropped, and a new key in DONE is taken with no bubble.
module key_schedule
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [3:0]       rd_round,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_hit,
  output logic             busy,
  output logic             keys_valid
);

  ks_state_t        state;
  logic [3:0]       cnt;
  logic [KEY_W-1:0] work;
  logic [KEY_W-1:0] next_key;
  logic [KEY_W-1:0] slot [0:NUM_ROUNDS];
  logic             rd_in_range;

  key_expand_round u_round (
    .key_in  (work),
    .round   (cnt),
    .key_out (next_key)
  );

  assign key_ready = (state != EXPAND);
  assign busy      = (state == EXPAND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      work       <= '0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) slot[i] <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (key_valid && key_ready) begin
            slot[0]    <= key_in;
            work       <= key_in;
            cnt        <= 4'd1;
            keys_valid <= 1'b0;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (cnt == 4'(i)) slot[i] <= next_key;
          end
          work <= next_key;
          // cnt parks at the last round so it never passes 10.
          if (cnt == 4'(NUM_ROUNDS)) begin
            state      <= DONE;
            keys_valid <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_round == 4'(i)) rd_key = slot[i];
    end
  end

  assign rd_in_range = (rd_round <= 4'(NUM_ROUNDS));
  assign rd_hit      = rd_in_range && (keys_valid || (busy && (rd_round < cnt)));

endmodule

// File: tb/tb_key_schedule.sv
// Scoreboard bench for key_schedule: reads and keys_valid latency are queued by the stimulus
// and compared by a separate negedge monitor against a FIPS-197 word-array model.
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_hit;
  logic         busy;
  logic         keys_valid;

  key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rd_round   (rd_round),
    .rd_key     (rd_key),
    .rd_hit     (rd_hit),
    .busy       (busy),
    .keys_valid (keys_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] k;
    logic         hit;
    logic [2:0]   st;   // {key_ready, busy, keys_valid}
  } exp_t;

  exp_t         exp_q[$];
  int           lat_q[$];
  int           n_chk = 0;
  int           n_pass = 0;
  logic         rd_chk = 1'b0;
  logic         to_flag = 1'b0;
  logic         end_req = 1'b0;
  logic         end_ack = 1'b0;
  string        to_name;
  logic [127:0] m_rk [0:10];
  logic [127:0] exp_slot [0:10];

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sb_ref(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] t;
    logic [7:0] s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv;
    t = inv;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      s = s ^ t;
    end
    return s ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_ref(t[31:24]), sb_ref(t[23:16]), sb_ref(t[15:8]), sb_ref(t[7:0])};
        t = t ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t e;
    int   neg_cnt;
    int   acc_edge;
    int   lat;
    int   want;
    logic prev_kv;
    neg_cnt  = 0;
    acc_edge = -1;
    prev_kv  = 1'b0;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (rd_chk) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL read_underflow: read at rd_round=%0d with nothing expected", rd_round);
        end else begin
          e = exp_q.pop_front();
          if (rd_key === e.k && rd_hit === e.hit && {key_ready, busy, keys_valid} === e.st)
            n_pass++;
          else
            $display("FAIL %s: rd_round=%0d got key=%h hit=%b rdy/busy/kv=%b, want key=%h hit=%b rdy/busy/kv=%b",
                     e.name, rd_round, rd_key, rd_hit, {key_ready, busy, keys_valid}, e.k, e.hit, e.st);
        end
      end
      if (keys_valid && !prev_kv) begin
        n_chk++;
        if (lat_q.size() == 0) begin
          $display("FAIL kv_rise_unexpected: keys_valid rose at edge %0d with no expansion expected", neg_cnt);
        end else begin
          want = lat_q.pop_front();
          lat  = neg_cnt - acc_edge;
          if (acc_edge >= 0 && lat == want) n_pass++;
          else $display("FAIL kv_latency: got %0d edges after accept, want %0d", lat, want);
        end
      end
      prev_kv = keys_valid;
      if (rst) acc_edge = -1;
      else if (key_valid && key_ready) acc_edge = neg_cnt + 1;
      if (to_flag) begin
        n_chk++;
        $display("FAIL %s: keys_valid got 0 after 20 cycles, want 1", to_name);
      end
      if (end_req && !end_ack) begin
        n_chk++;
        if (exp_q.size() == 0 && lat_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d reads and %0d latencies pending, want 0 and 0",
                      exp_q.size(), lat_q.size());
        end_ack = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] r, input string nm, input logic [127:0] k,
                    input logic h, input logic [2:0] st);
    exp_t e;
    e.name = nm;
    e.k    = k;
    e.hit  = h;
    e.st   = st;
    exp_q.push_back(e);
    rd_round = r;
    rd_chk   = 1'b1;
    tick();
    rd_chk = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    key_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int r = 0; r < 11; r++) exp_slot[r] = '0;
  endtask

  task automatic check_idle_zero(input string nm);
    for (int r = 0; r < 16; r++) rd(4'(r), nm, 128'h0, 1'b0, 3'b100);
  endtask

  task automatic accept(input logic [127:0] k, input bit completes);
    key_in    = k;
    key_valid = 1'b1;
    if (completes) lat_q.push_back(10);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_kv(input string nm);
    int n;
    n = 0;
    while (!keys_valid && n < 20) begin
      tick();
      n++;
    end
    if (!keys_valid) begin
      to_name = nm;
      to_flag = 1'b1;
      tick();
      to_flag = 1'b0;
    end
  endtask

  task automatic sweep_done(input string nm, input logic [127:0] k);
    int start;
    int r;
    model_expand(k);
    for (int i = 0; i < 11; i++) exp_slot[i] = m_rk[i];
    start = $urandom_range(0, 10);
    for (int i = 0; i < 11; i++) begin
      r = (start + i) % 11;
      rd(4'(r), nm, exp_slot[r], 1'b1, 3'b101);
    end
    rd(4'd11, {nm, "_oor11"}, 128'h0, 1'b0, 3'b101);
    rd(4'd15, {nm, "_oor15"}, 128'h0, 1'b0, 3'b101);
  endtask

  localparam logic [127:0] KEY_A = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] KEY_B = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

  initial begin : stimulus
    logic [127:0] k;
    logic [127:0] k2;
    int           j;
    int           r;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rd_round  = '0;
    tick();
    do_reset();
    check_idle_zero("reset");

    // Known-answer key, including the four listed slots
    accept(KEY_A, 1'b1);
    wait_kv("kat1_wait");
    sweep_done("kat1", KEY_A);
    rd(4'd1,  "kat1_slot1",  128'hE232FCF191129188B159E4E6D679A293, 1'b1, 3'b101);
    rd(4'd2,  "kat1_slot2",  128'h56082007C71AB18F76435569A03AF7FA, 1'b1, 3'b101);
    rd(4'd3,  "kat1_slot3",  128'hD2600DE7157ABC686339E901C3031EFB, 1'b1, 3'b101);
    rd(4'd10, "kat1_slot10", 128'h28FDDEF86DA4244ACCC0A4FE3B316F26, 1'b1, 3'b101);

    // FIPS-197 key, then a back-to-back key offered while DONE
    accept(KEY_B, 1'b1);
    wait_kv("fips_wait");
    sweep_done("fips", KEY_B);
    rd(4'd10, "fips_slot10", 128'hD014F9A8C9EE2589E13F0CC8B6630CA6, 1'b1, 3'b101);
    k = {$urandom, $urandom, $urandom, $urandom};
    key_in    = k;
    key_valid = 1'b1;
    lat_q.push_back(10);
    rd(4'd0, "done_ready", exp_slot[0], 1'b1, 3'b101);
    key_valid = 1'b0;
    rd(4'd0, "done_accept_kv_fall", k, 1'b1, 3'b010);
    wait_kv("b2b_wait");
    sweep_done("b2b", k);

    // Key offered at the 4th EXPAND cycle must be dropped
    k  = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k;
    model_expand(k);
    accept(k, 1'b1);
    tick();
    tick();
    tick();
    key_in    = k2;
    key_valid = 1'b1;
    rd(4'd2, "ignored_key_cnt4_rd2", m_rk[2], 1'b1, 3'b010);
    key_valid = 1'b0;
    wait_kv("ignore_wait");
    sweep_done("ignore", k);

    // Reset at the 5th EXPAND cycle, colliding with key_valid
    k = {$urandom, $urandom, $urandom, $urandom};
    accept(k, 1'b0);
    tick();
    tick();
    tick();
    rd(4'd7, "cnt4_rd7_stale", exp_slot[7], 1'b0, 3'b010);
    rst       = 1'b1;
    key_in    = ~k;
    key_valid = 1'b1;
    tick();
    rst       = 1'b0;
    key_valid = 1'b0;
    for (int i = 0; i < 11; i++) exp_slot[i] = '0;
    check_idle_zero("abort_reset");
    accept(KEY_A, 1'b1);
    wait_kv("after_abort_wait");
    sweep_done("after_abort", KEY_A);
    rd(4'd10, "after_abort_slot10", 128'h28FDDEF86DA4244ACCC0A4FE3B316F26, 1'b1, 3'b101);

    // Random keys with a random mid-expansion read
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) tick();
      model_expand(k);
      accept(k, 1'b1);
      j = $urandom_range(0, 8);
      repeat (j) tick();
      r = $urandom_range(0, 15);
      if (r > 10)
        rd(4'(r), "rand_mid_oor", 128'h0, 1'b0, 3'b010);
      else if (r < j + 1)
        rd(4'(r), "rand_mid_written", m_rk[r], 1'b1, 3'b010);
      else
        rd(4'(r), "rand_mid_stale", exp_slot[r], 1'b0, 3'b010);
      wait_kv("rand_wait");
      sweep_done("rand", k);
    end

    end_req = 1'b1;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
